// File: rtl/gpr_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// gpr_wb_arbiter_if
//   Bundles the writeback request bus and the GPR write/flag port of
//   gpr_wb_arbiter.
//   slave  : arbiter view. Takes hold/req_* and drives req_ready, gpr_*,
//            pend_mask and grant_id.
//   master : environment view. Drives the requests and observes the results.
//   Request vectors are packed per requester. Slice i is
//   [i*AW +: AW] / [i*DW +: DW] / [i*2 +: 2].
// ----------------------------------------------------------------------------
interface gpr_wb_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
);
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ*2-1:0]    req_flagop;
    logic [NREQ*DW-1:0]   req_nflag;
    logic [NREQ-1:0]      req_ready;
    logic                 gpr_we;
    logic [1:0]           gpr_flagop;
    logic [AW-1:0]        gpr_awr;
    logic [DW-1:0]        gpr_din;
    logic [DW-1:0]        gpr_nflag;
    logic [2**AW-1:0]     pend_mask;
    logic [1:0]           grant_id;

    modport slave (
        input  hold, req_valid, req_we, req_addr, req_data, req_flagop, req_nflag,
        output req_ready, gpr_we, gpr_flagop, gpr_awr, gpr_din, gpr_nflag,
               pend_mask, grant_id
    );

    modport master (
        output hold, req_valid, req_we, req_addr, req_data, req_flagop, req_nflag,
        input  req_ready, gpr_we, gpr_flagop, gpr_awr, gpr_din, gpr_nflag,
               pend_mask, grant_id
    );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// ----------------------------------------------------------------------------
// gpr_wb_arbiter
//   Shares the single GPR write/flag port between NREQ writeback sources
//   (0 = MEM load, 1 = MDU, 2 = ALU). Each cycle it grants at most one
//   request. The granted payload is latched into a registered output stage
//   that drives the GPR WE/FlagOp/AWr/Din/NFlag inputs. pend_mask reports
//   every register that has a write requested or held in the output stage,
//   so issue logic can stall on RAW hazards.
//
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : gpr_wb_arbiter_if.slave
//            hold       : grant nothing this cycle
//            req_*      : per-requester valid/we/addr/data/flagop/nflag
//            req_ready  : one-hot grant (combinational)
//            gpr_*      : registered GPR write port
//            pend_mask  : pending-write mask, bit 0 always 0
//            grant_id   : index of last accepted requester
//
// Configuration
//   WB_RR_EN defined   : round-robin arbitration starting at an internal
//                        pointer. After an accept the pointer moves to
//                        granted+1 mod NREQ.
//   WB_RR_EN undefined : fixed priority, where the lowest index wins.
//
// Flag op codes: 0 = DIS, 1 = SET (flag only), 2 = SET_AND_WR, 3 = reserved.
// ----------------------------------------------------------------------------
module gpr_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic             clk,
    input  logic             reset,
    gpr_wb_arbiter_if.slave  bus
);
    localparam logic [1:0] FLAG_OP_DIS        = 2'd0;
    localparam logic [1:0] FLAG_OP_SET_AND_WR = 2'd2;

    logic [NREQ-1:0]  w_ready;
    logic             w_accept;
    logic [1:0]       w_gid;
    logic             w_we;
    logic [1:0]       w_flagop;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_data;
    logic [DW-1:0]    w_nflag;
    logic             w_we_clean;
    logic [2**AW-1:0] w_pend;

    logic             r_we;
    logic [1:0]       r_flagop;
    logic [AW-1:0]    r_awr;
    logic [DW-1:0]    r_din;
    logic [DW-1:0]    r_nflag;
    logic [1:0]       r_gid;

`ifdef WB_RR_EN
    logic [1:0]       r_ptr;
    logic [2:0]       w_idx;
`endif

    // Grant selection. No grant is made while reset or hold is high.
    always_comb begin
        w_accept = 1'b0;
        w_gid    = '0;
`ifdef WB_RR_EN
        w_idx    = '0;
`endif
        if (!reset && !bus.hold) begin
`ifdef WB_RR_EN
            // Visit requesters in the order ptr, ptr+1, ... (mod NREQ).
            // The first valid requester found wins.
            for (int unsigned k = 0; k < NREQ; k++) begin
                w_idx = 3'(r_ptr) + 3'(k);
                if (w_idx >= 3'(NREQ))
                    w_idx = w_idx - 3'(NREQ);
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (!w_accept && (w_idx == 3'(i)) && bus.req_valid[i]) begin
                        w_accept = 1'b1;
                        w_gid    = 2'(i);
                    end
                end
            end
`else
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!w_accept && bus.req_valid[i]) begin
                    w_accept = 1'b1;
                    w_gid    = 2'(i);
                end
            end
`endif
        end
    end

    // One-hot ready and payload mux for the granted requester.
    always_comb begin
        w_ready  = '0;
        w_we     = bus.req_we[0];
        w_addr   = bus.req_addr[0 +: AW];
        w_data   = bus.req_data[0 +: DW];
        w_flagop = bus.req_flagop[0 +: 2];
        w_nflag  = bus.req_nflag[0 +: DW];
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gid == 2'(i)) begin
                w_ready[i] = w_accept;
                w_we       = bus.req_we[i];
                w_addr     = bus.req_addr[i*AW +: AW];
                w_data     = bus.req_data[i*DW +: DW];
                w_flagop   = bus.req_flagop[i*2 +: 2];
                w_nflag    = bus.req_nflag[i*DW +: DW];
            end
        end
    end

    // Suppress writes to r0 and writes under flag-only or reserved flag ops.
    assign w_we_clean = w_we && (w_addr != '0) &&
                        ((w_flagop == FLAG_OP_DIS) || (w_flagop == FLAG_OP_SET_AND_WR));

    // Registered output stage. When nothing is accepted, the stage goes idle
    // but the addr/data fields keep their last values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_flagop <= FLAG_OP_DIS;
            r_awr    <= '0;
            r_din    <= '0;
            r_nflag  <= '0;
            r_gid    <= '0;
        end else if (w_accept) begin
            r_we     <= w_we_clean;
            r_flagop <= w_flagop;
            r_awr    <= w_addr;
            r_din    <= w_data;
            r_nflag  <= w_nflag;
            r_gid    <= w_gid;
        end else begin
            r_we     <= 1'b0;
            r_flagop <= FLAG_OP_DIS;
        end
    end

`ifdef WB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ptr <= '0;
        else if (w_accept)
            r_ptr <= (w_gid == 2'(NREQ - 1)) ? 2'd0 : w_gid + 2'd1;
    end
`endif

    // Pending-write mask. The request terms are gated by reset so the mask
    // reads clear while the block is held in reset.
    always_comb begin
        w_pend = '0;
        if (!reset) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_we[i])
                    w_pend[bus.req_addr[i*AW +: AW]] = 1'b1;
            end
        end
        if (r_we)
            w_pend[r_awr] = 1'b1;
        w_pend[0] = 1'b0;
    end

    assign bus.req_ready  = w_ready;
    assign bus.gpr_we     = r_we;
    assign bus.gpr_flagop = r_flagop;
    assign bus.gpr_awr    = r_awr;
    assign bus.gpr_din    = r_din;
    assign bus.gpr_nflag  = r_nflag;
    assign bus.pend_mask  = w_pend;
    assign bus.grant_id   = r_gid;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;
    localparam logic [1:0] F_DIS = 2'd0;
    localparam logic [1:0] F_SET = 2'd1;
    localparam logic [1:0] F_SWR = 2'd2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [31:0] m_gpr [32] = '{default: '0};
    logic [31:0] m_flag = '0;

    always #5 clk = ~clk;

    gpr_wb_arbiter_if #(.NREQ(3), .AW(5), .DW(32)) bus ();

    gpr_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // GPR file and flag register fed by the arbiter's output stage
    always @(posedge clk) begin
        if (bus.gpr_we)
            m_gpr[bus.gpr_awr] <= bus.gpr_din;
        if (bus.gpr_flagop == F_SET || bus.gpr_flagop == F_SWR)
            m_flag <= bus.gpr_nflag;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic v, input logic we,
                           input logic [4:0] a, input logic [31:0] d,
                           input logic [1:0] f, input logic [31:0] nf);
        bus.req_valid[i]          = v;
        bus.req_we[i]             = we;
        bus.req_addr[i*5 +: 5]    = a;
        bus.req_data[i*32 +: 32]  = d;
        bus.req_flagop[i*2 +: 2]  = f;
        bus.req_nflag[i*32 +: 32] = nf;
    endtask

    task automatic clear_reqs();
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_flagop = '0;
        bus.req_nflag  = '0;
    endtask

    initial begin
        int unsigned exp_g;
        bus.hold = 1'b0;
        clear_reqs();
        // Reset held with valid requests present
        set_req(0, 1'b1, 1'b1, 5'd1, 32'h11, F_DIS, 32'h0);
        set_req(1, 1'b1, 1'b1, 5'd2, 32'h22, F_DIS, 32'h0);
        set_req(2, 1'b1, 1'b1, 5'd3, 32'h33, F_DIS, 32'h0);
        #2;
        chk("rst_ready",  64'(bus.req_ready),  64'h0);
        chk("rst_pend",   64'(bus.pend_mask),  64'h0);
        chk("rst_we",     64'(bus.gpr_we),     64'h0);
        chk("rst_flagop", 64'(bus.gpr_flagop), 64'(F_DIS));
        chk("rst_awr",    64'(bus.gpr_awr),    64'h0);
        chk("rst_din",    64'(bus.gpr_din),    64'h0);
        chk("rst_nflag",  64'(bus.gpr_nflag),  64'h0);
        chk("rst_gid",    64'(bus.grant_id),   64'h0);
        clear_reqs();
        tick();
        tick();
        reset = 1'b0;

        // Single ALU request, addr 5
        set_req(2, 1'b1, 1'b1, 5'd5, 32'h1234, F_DIS, 32'h0);
        #1;
        chk("alu_ready", 64'(bus.req_ready), 64'b100);
        chk("alu_pend",  64'(bus.pend_mask), 64'h20);
        tick();
        clear_reqs();
        #1;
        chk("alu_we",   64'(bus.gpr_we),     64'h1);
        chk("alu_awr",  64'(bus.gpr_awr),    64'd5);
        chk("alu_din",  64'(bus.gpr_din),    64'h1234);
        chk("alu_fop",  64'(bus.gpr_flagop), 64'(F_DIS));
        chk("alu_gid",  64'(bus.grant_id),   64'd2);
        chk("alu_pend2", 64'(bus.pend_mask), 64'h20);
        tick();
        chk("alu_r5",    64'(m_gpr[5]),      64'h1234);
        chk("alu_idle",  64'(bus.gpr_we),    64'h0);
        chk("alu_pend3", 64'(bus.pend_mask), 64'h0);

        // Addr 0 with SET_AND_WR: only the flag is written
        set_req(2, 1'b1, 1'b1, 5'd0, 32'hDEAD, F_SWR, 32'h1);
        #1;
        chk("a0_ready", 64'(bus.req_ready), 64'b100);
        chk("a0_pend",  64'(bus.pend_mask), 64'h0);
        tick();
        clear_reqs();
        chk("a0_we",  64'(bus.gpr_we),     64'h0);
        chk("a0_fop", 64'(bus.gpr_flagop), 64'(F_SWR));
        tick();
        chk("a0_flag", 64'(m_flag),   64'h1);
        chk("a0_r0",   64'(m_gpr[0]), 64'h0);

        // Flag-only SET to addr 4 must not write the register
        set_req(2, 1'b1, 1'b1, 5'd4, 32'hBEEF, F_SET, 32'h5);
        tick();
        clear_reqs();
        chk("set_we",  64'(bus.gpr_we),     64'h0);
        chk("set_fop", 64'(bus.gpr_flagop), 64'(F_SET));
        tick();
        chk("set_flag", 64'(m_flag),   64'h5);
        chk("set_r4",   64'(m_gpr[4]), 64'h0);

        // All three requesters valid for six cycles
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1'b1, 1'b1, 5'd1, 32'h100 + 32'(k), F_DIS, 32'h0);
            set_req(1, 1'b1, 1'b1, 5'd2, 32'h200 + 32'(k), F_DIS, 32'h0);
            set_req(2, 1'b1, 1'b1, 5'd3, 32'h300 + 32'(k), F_DIS, 32'h0);
`ifdef WB_RR_EN
            exp_g = 32'(k % 3);
`else
            exp_g = 0;
`endif
            #1;
            chk("arb_ready", 64'(bus.req_ready), 64'(1 << exp_g));
            tick();
            chk("arb_gid", 64'(bus.grant_id), 64'(exp_g));
            chk("arb_awr", 64'(bus.gpr_awr),  64'(exp_g + 1));
        end
        clear_reqs();
        tick();
        chk("arb_idle", 64'(bus.gpr_we), 64'h0);

        // Hold for three cycles with MEM pending on addr 7
        bus.hold = 1'b1;
        set_req(0, 1'b1, 1'b1, 5'd7, 32'h77, F_DIS, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_ready", 64'(bus.req_ready), 64'h0);
            chk("hold_pend",  64'(bus.pend_mask), 64'h80);
            tick();
            chk("hold_we", 64'(bus.gpr_we), 64'h0);
        end
        bus.hold = 1'b0;
        #1;
        chk("unhold_ready", 64'(bus.req_ready), 64'b001);
        tick();
        clear_reqs();
        bus.hold = 1'b1;
        chk("unhold_we",  64'(bus.gpr_we),   64'h1);
        chk("unhold_awr", 64'(bus.gpr_awr),  64'd7);
        chk("unhold_gid", 64'(bus.grant_id), 64'd0);
        tick();
        chk("hold_inflight_r7", 64'(m_gpr[7]), 64'h77);
        bus.hold = 1'b0;

        // Back-to-back writes to r3, MEM then ALU
        set_req(0, 1'b1, 1'b1, 5'd3, 32'hAAAA, F_DIS, 32'h0);
        #1;
        chk("b2b_ready0", 64'(bus.req_ready), 64'b001);
        tick();
        clear_reqs();
        set_req(2, 1'b1, 1'b1, 5'd3, 32'hBBBB, F_DIS, 32'h0);
        #1;
        chk("b2b_ready2", 64'(bus.req_ready), 64'b100);
        chk("b2b_pend1",  64'(bus.pend_mask), 64'h8);
        tick();
        clear_reqs();
        #1;
        chk("b2b_pend2", 64'(bus.pend_mask), 64'h8);
        chk("b2b_r3a",   64'(m_gpr[3]),      64'hAAAA);
        tick();
        chk("b2b_r3b",   64'(m_gpr[3]),      64'hBBBB);
        chk("b2b_pend3", 64'(bus.pend_mask), 64'h0);

        // Reset asserted mid-cycle with an entry in the output stage
        set_req(1, 1'b1, 1'b1, 5'd9, 32'h9999, F_SWR, 32'h3);
        tick();
        chk("mr_we_pre", 64'(bus.gpr_we), 64'h1);
        #3;
        reset = 1'b1;
        #1;
        chk("mr_we",    64'(bus.gpr_we),     64'h0);
        chk("mr_fop",   64'(bus.gpr_flagop), 64'(F_DIS));
        chk("mr_awr",   64'(bus.gpr_awr),    64'h0);
        chk("mr_din",   64'(bus.gpr_din),    64'h0);
        chk("mr_gid",   64'(bus.grant_id),   64'h0);
        chk("mr_ready", 64'(bus.req_ready),  64'h0);
        chk("mr_pend",  64'(bus.pend_mask),  64'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("mr_after_ready", 64'(bus.req_ready), 64'b010);
        clear_reqs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
